mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/cache_pkg.sv | 22 ++
 rtl/mem_ctrl_if.sv | 42 ++++
 rtl/mem_ctrl_storage.sv | 38 +++
 rtl/mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Definitions shared by the cache and the memory controller: the C2 command
// encoding used on the cache <-> memory bus and the default line and beat
// geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

  // C2 bus command encoding
  typedef enum logic [1:0] {
    C2Nop       = 2'd0,
    C2Response  = 2'd1,
    C2ReadLine  = 2'd2,
    C2WriteLine = 2'd3
  } c2_cmd_e;

  // Default geometry: bytes per cache line and bytes per data beat
  localparam int unsigned LINE_BYTES_DEF = 16;
  localparam int unsigned BUS_BYTES_DEF  = 2;

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// C2 bus between the cache (master) and the memory controller (slave).
// Signals:
//   addr_in  : line address, cache -> memory
//   cmd_in   : C2 command, cache -> memory
//   data_in  : write beat, cache -> memory
//   cmd_out  : C2 command, memory -> cache
//   data_out : read beat, memory -> cache
//   bus_oe   : memory owns cmd/data (drives the top-level tri-state)
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int unsigned LADDR_BITS = 6,
  parameter int unsigned BUS_BYTES  = cache_pkg::BUS_BYTES_DEF
);

  logic [LADDR_BITS-1:0]  addr_in;
  cache_pkg::c2_cmd_e     cmd_in;
  logic [BUS_BYTES*8-1:0] data_in;
  cache_pkg::c2_cmd_e     cmd_out;
  logic [BUS_BYTES*8-1:0] data_out;
  logic                   bus_oe;

  modport master (
    output addr_in,
    output cmd_in,
    output data_in,
    input  cmd_out,
    input  data_out,
    input  bus_oe
  );

  modport slave (
    input  addr_in,
    input  cmd_in,
    input  data_in,
    output cmd_out,
    output data_out,
    output bus_oe
  );

endinterface

// File: rtl/mem_ctrl_storage.sv
// -----------------------------------------------------------------------------
// mem_ctrl_storage
// Line array of 2^LADDR_BITS lines. One synchronous full-line write port and
// one combinational read port.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write line address
//   wdata : write line data
//   raddr : read line address
//   rdata : read line data (combinational)
// -----------------------------------------------------------------------------
module mem_ctrl_storage #(
  parameter int unsigned LINE_BITS  = 128,
  parameter int unsigned LADDR_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LADDR_BITS-1:0] waddr,
  input  logic [LINE_BITS-1:0]  wdata,
  input  logic [LADDR_BITS-1:0] raddr,
  output logic [LINE_BITS-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** LADDR_BITS;

  logic [LINE_BITS-1:0] mem_q [DEPTH];

  // No reset: memory contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Line-oriented memory controller behind a cache. Accepts READ_LINE and
// WRITE_LINE commands, collects write beats into a line buffer, waits
// MEM_LATENCY cycles, then answers with RESPONSE: one cycle for a write (the
// line is committed on that edge), BEATS cycles of data for a read.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : C2 bus (slave side), see mem_ctrl_if
// -----------------------------------------------------------------------------
module mem_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = LINE_BYTES_DEF,
  parameter int unsigned BUS_BYTES   = BUS_BYTES_DEF,
  parameter int unsigned LADDR_BITS  = 6,
  parameter int unsigned MEM_LATENCY = 100
) (
  input logic       clk,
  input logic       reset,
  mem_ctrl_if.slave bus
);

  localparam int unsigned BEATS     = LINE_BYTES / BUS_BYTES;
  localparam int unsigned BUS_BITS  = BUS_BYTES * 8;
  localparam int unsigned LINE_BITS = LINE_BYTES * 8;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W     = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY);

  // Beat 0 occupies the low BUS_BITS of the line.
  typedef logic [BEATS-1:0][BUS_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    StIdle,
    StWrRx,
    StWait,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  op_write_q, op_write_d;
  logic [LADDR_BITS-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  line_t                 line_q, line_d;

  logic  st_we;
  line_t rd_line;

  mem_ctrl_storage #(
    .LINE_BITS  (LINE_BITS),
    .LADDR_BITS (LADDR_BITS)
  ) u_storage (
    .clk   (clk),
    .we    (st_we),
    .waddr (addr_q),
    .wdata (line_q),
    .raddr (addr_q),
    .rdata (rd_line)
  );

  always_comb begin
    state_d       = state_q;
    op_write_d    = op_write_q;
    addr_d        = addr_q;
    beat_d        = beat_q;
    cnt_d         = cnt_q;
    line_d        = line_q;
    st_we         = 1'b0;
    bus.bus_oe    = 1'b0;
    bus.cmd_out   = C2Nop;
    bus.data_out  = '0;

    unique case (state_q)
      StIdle: begin
        case (bus.cmd_in)
          C2ReadLine: begin
            addr_d     = bus.addr_in;
            op_write_d = 1'b0;
            cnt_d      = CNT_LOAD;
            state_d    = StWait;
          end
          C2WriteLine: begin
            addr_d     = bus.addr_in;
            op_write_d = 1'b1;
            line_d[0]  = bus.data_in;
            cnt_d      = CNT_LOAD;
            if (BEATS > 1) begin
              beat_d  = BEAT_W'(1);
              state_d = StWrRx;
            end else begin
              beat_d  = '0;
              state_d = StWait;
            end
          end
          default: ;
        endcase
      end

      StWrRx: begin
        line_d[beat_q] = bus.data_in;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = StWait;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      // Stays MEM_LATENCY cycles, but at least one, so latency 0 reaches
      // RESP on the edge after WAIT is entered. The counter never wraps.
      StWait: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          beat_d  = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      StResp: begin
        bus.bus_oe  = 1'b1;
        bus.cmd_out = C2Response;
        if (op_write_q) begin
          st_we   = 1'b1;
          state_d = StIdle;
        end else begin
          bus.data_out = rd_line[beat_q];
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl: one instance with MEM_LATENCY=4, one with
// MEM_LATENCY=0. Inputs change 1 time unit after the rising edge and outputs
// are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;
  import cache_pkg::*;

  logic clk;
  logic reset4;
  logic reset0;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_ctrl_if #(.LADDR_BITS(6), .BUS_BYTES(2)) bus4 ();
  mem_ctrl_if #(.LADDR_BITS(6), .BUS_BYTES(2)) bus0 ();

  mem_ctrl #(
    .LINE_BYTES  (16),
    .BUS_BYTES   (2),
    .LADDR_BITS  (6),
    .MEM_LATENCY (4)
  ) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  mem_ctrl #(
    .LINE_BYTES  (16),
    .BUS_BYTES   (2),
    .LADDR_BITS  (6),
    .MEM_LATENCY (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line whose beat k is base + k*step.
  function automatic logic [127:0] mk_line(input logic [15:0] base, input logic [15:0] step);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) begin
      l[k*16 +: 16] = base + step * 16'(k);
    end
    return l;
  endfunction

  // Full write on the latency-4 instance, including response timing.
  task automatic write_line4(input logic [5:0] a, input logic [127:0] l, input string tag);
    bus4.addr_in = a;
    bus4.cmd_in  = C2WriteLine;
    bus4.data_in = l[15:0];
    tick();
    bus4.cmd_in = C2Nop;
    for (int k = 1; k < 8; k++) begin
      bus4.data_in = l[k*16 +: 16];
      tick();
    end
    bus4.data_in = '0;
    check_eq({tag, "_wait0_oe"}, 32'(bus4.bus_oe), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq({tag, "_wait_oe"}, 32'(bus4.bus_oe), 32'd0);
    end
    tick();
    check_eq({tag, "_resp_oe"}, 32'(bus4.bus_oe), 32'd1);
    check_eq({tag, "_resp_cmd"}, 32'(bus4.cmd_out), 32'(C2Response));
    tick();
    check_eq({tag, "_done_oe"}, 32'(bus4.bus_oe), 32'd0);
    check_eq({tag, "_done_cmd"}, 32'(bus4.cmd_out), 32'(C2Nop));
  endtask

  task automatic read_line4(input logic [5:0] a, input logic [127:0] l, input string tag);
    bus4.addr_in = a;
    bus4.cmd_in  = C2ReadLine;
    tick();
    bus4.cmd_in = C2Nop;
    check_eq({tag, "_wait0_oe"}, 32'(bus4.bus_oe), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq({tag, "_wait_oe"}, 32'(bus4.bus_oe), 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq({tag, "_beat_oe"}, 32'(bus4.bus_oe), 32'd1);
      check_eq({tag, "_beat_cmd"}, 32'(bus4.cmd_out), 32'(C2Response));
      check_eq({tag, "_beat_data"}, 32'(bus4.data_out), 32'(l[k*16 +: 16]));
    end
    tick();
    check_eq({tag, "_done_oe"}, 32'(bus4.bus_oe), 32'd0);
    check_eq({tag, "_done_cmd"}, 32'(bus4.cmd_out), 32'(C2Nop));
    check_eq({tag, "_done_data"}, 32'(bus4.data_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] l5, l0, l63, l9a, l9b, l3;
    n_checks = 0;
    n_errors = 0;
    l5  = mk_line(16'h0100, 16'h0101);
    l0  = mk_line(16'hA000, 16'h0001);
    l63 = mk_line(16'h5A3C, 16'h0111);
    l9a = mk_line(16'h9900, 16'h0002);
    l9b = mk_line(16'h1234, 16'h0003);
    l3  = mk_line(16'h3300, 16'h0010);

    reset4 = 1'b0;
    reset0 = 1'b0;
    bus4.addr_in = '0;
    bus4.cmd_in  = C2Nop;
    bus4.data_in = '0;
    bus0.addr_in = '0;
    bus0.cmd_in  = C2Nop;
    bus0.data_in = '0;

    tick();
    check_eq("rst4_oe", 32'(bus4.bus_oe), 32'd0);
    check_eq("rst4_cmd", 32'(bus4.cmd_out), 32'(C2Nop));
    check_eq("rst4_data", 32'(bus4.data_out), 32'd0);
    check_eq("rst0_oe", 32'(bus0.bus_oe), 32'd0);
    tick();
    reset4 = 1'b1;
    reset0 = 1'b1;
    tick();

    // RESPONSE and NOP in IDLE are ignored
    for (int i = 0; i < 10; i++) begin
      bus4.cmd_in  = (i % 2 == 0) ? C2Response : C2Nop;
      bus4.addr_in = 6'(i);
      tick();
      check_eq("idle_ignore_oe", 32'(bus4.bus_oe), 32'd0);
    end
    bus4.cmd_in = C2Nop;

    write_line4(6'd5, l5, "wr5");
    read_line4(6'd5, l5, "rd5");

    // Address extremes must not alias
    write_line4(6'd0, l0, "wr0");
    write_line4(6'd63, l63, "wr63");
    read_line4(6'd0, l0, "rd0");
    read_line4(6'd63, l63, "rd63");

    // Reset in the middle of a write leaves storage untouched
    write_line4(6'd9, l9a, "wr9a");
    bus4.addr_in = 6'd9;
    bus4.cmd_in  = C2WriteLine;
    bus4.data_in = l9b[15:0];
    tick();
    bus4.cmd_in = C2Nop;
    for (int k = 1; k < 3; k++) begin
      bus4.data_in = l9b[k*16 +: 16];
      tick();
    end
    bus4.data_in = l9b[47:32];
    reset4 = 1'b0;
    #1;
    check_eq("rst_mid_wr_oe", 32'(bus4.bus_oe), 32'd0);
    check_eq("rst_mid_wr_cmd", 32'(bus4.cmd_out), 32'(C2Nop));
    tick();
    tick();
    reset4 = 1'b1;
    bus4.data_in = '0;
    tick();
    read_line4(6'd9, l9a, "rd9_after_rst");

    // Latency 0: write, then read with a competing READ_LINE during RESP
    bus0.addr_in = 6'd3;
    bus0.cmd_in  = C2WriteLine;
    bus0.data_in = l3[15:0];
    tick();
    bus0.cmd_in = C2Nop;
    for (int k = 1; k < 8; k++) begin
      bus0.data_in = l3[k*16 +: 16];
      tick();
    end
    check_eq("lat0_wr_wait_oe", 32'(bus0.bus_oe), 32'd0);
    tick();
    check_eq("lat0_wr_resp_oe", 32'(bus0.bus_oe), 32'd1);
    check_eq("lat0_wr_resp_cmd", 32'(bus0.cmd_out), 32'(C2Response));
    tick();
    check_eq("lat0_wr_done_oe", 32'(bus0.bus_oe), 32'd0);

    bus0.cmd_in = C2ReadLine;
    tick();
    check_eq("lat0_rd_wait_oe", 32'(bus0.bus_oe), 32'd0);
    bus0.addr_in = 6'd7;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("lat0_rd_oe", 32'(bus0.bus_oe), 32'd1);
      check_eq("lat0_rd_data", 32'(bus0.data_out), 32'(l3[k*16 +: 16]));
    end
    bus0.cmd_in = C2Nop;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("lat0_b2b_ignored_oe", 32'(bus0.bus_oe), 32'd0);
    end

    // Reset during RESP drops the outputs at once
    bus0.addr_in = 6'd3;
    bus0.cmd_in  = C2ReadLine;
    tick();
    bus0.cmd_in = C2Nop;
    tick();
    check_eq("lat0_rd2_beat0", 32'(bus0.data_out), 32'(l3[15:0]));
    tick();
    check_eq("lat0_rd2_oe", 32'(bus0.bus_oe), 32'd1);
    reset0 = 1'b0;
    #1;
    check_eq("rst_resp_oe", 32'(bus0.bus_oe), 32'd0);
    check_eq("rst_resp_cmd", 32'(bus0.cmd_out), 32'(C2Nop));
    check_eq("rst_resp_data", 32'(bus0.data_out), 32'd0);
    tick();
    reset0 = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
